// File: rtl/param_seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// The helpers size the length field and build the per-length compare mask.
package param_seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    // Number of bits needed to hold any value from 0 to max_len inclusive.
    function automatic int clog2_len(input int max_len);
        int w;
        w = 0;
        while ((1 << w) < (max_len + 1)) begin
            w++;
        end
        return w;
    endfunction

    // Mask with the low 'len' bits set; callers slice it down to MAX_LEN bits.
    function automatic logic [31:0] len_mask(input int len);
        if (len >= 32) begin
            return '1;
        end
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/param_seq_detect_if.sv
// Serial data, configuration and result signals of the pattern detector.
// The slave modport is the detector's side; the master modport is the driver's side.
interface param_seq_detect_if
    import param_seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = clog2_len(MAX_LEN)
);
    logic               inp_bit;
    logic               inp_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   cfg_len;

    modport slave (
        input  inp_bit, inp_valid, cfg_load, pattern, pat_len, overlap_en,
        output seq_seen, match_count, cfg_len
    );

    modport master (
        output inp_bit, inp_valid, cfg_load, pattern, pat_len, overlap_en,
        input  seq_seen, match_count, cfg_len
    );
endinterface

// File: rtl/param_seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/param_seq_detect.sv
// Runtime-programmable serial pattern detector with overlap control and a match counter.
// All outputs are registered; a match pulses seq_seen one cycle after its final bit.
module param_seq_detect
    import param_seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = clog2_len(MAX_LEN)
) (
    input logic                 clk,
    input logic                 reset,
    param_seq_detect_if.slave   bus
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               seen_q, seen_d;

    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [31:0]        mask_full;
    logic [LEN_W-1:0]   fill_inc;
    logic               match;
    logic [CNT_W-1:0]   count;

    // Candidate history/fill after accepting this bit; the match is judged on them.
    always_comb begin
        shifted   = {hist_q[MAX_LEN-2:0], bus.inp_bit};
        fill_inc  = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
        mask_full = len_mask(int'(len_q));
        mask      = mask_full[MAX_LEN-1:0];
        match     = bus.inp_valid && !bus.cfg_load && (len_q != '0) &&
                    (fill_inc >= len_q) && (((shifted ^ pat_q) & mask) == '0);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        seen_d = 1'b0;
        if (bus.cfg_load) begin
            pat_d  = bus.pattern;
            len_d  = (bus.pat_len > LEN_MAX) ? LEN_MAX : bus.pat_len;
            ovl_d  = bus.overlap_en;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.inp_valid) begin
            hist_d = shifted;
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            seen_d = match;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments; comb blocks use blocking ones.
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b1;
            seen_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            seen_q <= seen_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (bus.cfg_load),
        .count (count)
    );

    assign bus.seq_seen    = seen_q;
    assign bus.match_count = count;
    assign bus.cfg_len     = len_q;
endmodule

// File: tb/tb_param_seq_detect.sv
// Bench for param_seq_detect: two instances (8-bit and 2-bit counters) share one stimulus
// and are compared each cycle against a queue-based model of the detection rules.
module tb_param_seq_detect;
    localparam int ML = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_seq_detect_if #(.MAX_LEN(ML), .CNT_W(8)) bus_a ();
    param_seq_detect_if #(.MAX_LEN(ML), .CNT_W(2)) bus_b ();

    param_seq_detect #(.MAX_LEN(ML), .CNT_W(8)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    param_seq_detect #(.MAX_LEN(ML), .CNT_W(2)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cfg_pat;
    logic [3:0] cfg_plen;
    logic       cfg_ovl;

    // Reference model: list of accepted bits plus count of bits since the last restart.
    bit         m_q[$];
    int         m_fresh;
    int         m_len;
    bit         m_ovl;
    logic [7:0] m_pat;
    bit         m_seen;
    int         m_cnt8;
    int         m_cnt2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit cfg, input bit vld, input bit b);
        bit hit;
        int n;
        if (rst) begin
            m_q.delete(); m_fresh = 0; m_len = 0; m_pat = '0; m_ovl = 1'b1;
            m_seen = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (cfg) begin
            m_pat = cfg_pat; m_len = (cfg_plen > ML) ? ML : int'(cfg_plen); m_ovl = cfg_ovl;
            m_q.delete(); m_fresh = 0; m_seen = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (vld) begin
            m_q.push_back(b);
            if (m_q.size() > 64) void'(m_q.pop_front());
            m_fresh++;
            hit = (m_len > 0) && (m_fresh >= m_len);
            n = m_q.size();
            for (int i = 0; i < m_len && hit; i++) begin
                if (m_q[n-1-i] != m_pat[i]) hit = 1'b0;
            end
            m_seen = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) m_fresh = 0;
            end
        end else begin
            m_seen = 1'b0;
        end
    endtask

    task automatic cycle(input bit rst, input bit cfg, input bit vld, input bit b);
        reset = rst;
        bus_a.cfg_load = cfg;  bus_b.cfg_load = cfg;
        bus_a.inp_valid = vld; bus_b.inp_valid = vld;
        bus_a.inp_bit = b;     bus_b.inp_bit = b;
        bus_a.pattern = cfg_pat;     bus_b.pattern = cfg_pat;
        bus_a.pat_len = cfg_plen;    bus_b.pat_len = cfg_plen;
        bus_a.overlap_en = cfg_ovl;  bus_b.overlap_en = cfg_ovl;
        model_step(rst, cfg, vld, b);
        @(posedge clk);
        #1;
        check("seen_a", 32'(bus_a.seq_seen), 32'(m_seen));
        check("seen_b", 32'(bus_b.seq_seen), 32'(m_seen));
        check("cnt_a", 32'(bus_a.match_count), 32'(m_cnt8));
        check("cnt_b", 32'(bus_b.match_count), 32'(m_cnt2));
        check("cfg_len", 32'(bus_a.cfg_len), 32'(m_len));
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        cfg_pat = pat; cfg_plen = len; cfg_ovl = ovl;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        // Scramble the config inputs to show they are ignored without cfg_load.
        cfg_pat = 8'($urandom); cfg_plen = 4'($urandom); cfg_ovl = 1'($urandom);
    endtask

    // Send n bits, first bit is bits[n-1].
    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b1, bits[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'($urandom));
    endtask

    initial begin
        cfg_pat = '0; cfg_plen = '0; cfg_ovl = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("reset_len", 32'(bus_a.cfg_len), 32'd0);
        idle(2);

        // Overlapping 1011 on 1011011: pulses after bits 4 and 7.
        do_cfg(8'b1011, 4'd4, 1'b1);
        send(32'b1011011, 7);
        check("ovl_count", 32'(bus_a.match_count), 32'd2);

        // Non-overlapping: only bit 4 in the first seven, then bit 10.
        do_cfg(8'b1011, 4'd4, 1'b0);
        send(32'b1011011, 7);
        check("novl_count7", 32'(bus_a.match_count), 32'd1);
        send(32'b011, 3);
        check("novl_count10", 32'(bus_a.match_count), 32'd2);

        // Valid gaps between bits 2 and 3.
        do_cfg(8'b1011, 4'd4, 1'b1);
        send(32'b10, 2);
        idle(3);
        send(32'b11, 2);
        check("gap_count", 32'(bus_a.match_count), 32'd1);

        // Saturation with a one-bit pattern.
        do_cfg(8'b1, 4'd1, 1'b1);
        send(32'hFF, 8);
        check("sat_cnt_b", 32'(bus_b.match_count), 32'd3);
        check("sat_cnt_a", 32'(bus_a.match_count), 32'd8);

        // Reset mid-pattern discards progress.
        do_cfg(8'b1011, 4'd4, 1'b1);
        send(32'b101, 3);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        do_cfg(8'b1011, 4'd4, 1'b1);
        send(32'b1, 1);
        check("rst_nopulse", 32'(bus_a.match_count), 32'd0);
        send(32'b1011, 4);
        check("rst_pulse", 32'(bus_a.match_count), 32'd1);

        // cfg_load mid-pattern, and a bit presented alongside cfg_load is dropped.
        send(32'b101, 3);
        do_cfg(8'b1011, 4'd4, 1'b1);
        send(32'b1, 1);
        check("cfg_nopulse", 32'(bus_a.match_count), 32'd0);
        cfg_pat = 8'b1011; cfg_plen = 4'd4; cfg_ovl = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        send(32'b011, 3);
        check("cfg_bit_drop", 32'(bus_a.match_count), 32'd0);

        // Length 0 disables detection.
        do_cfg(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b1, 1'($urandom));
        check("len0_count", 32'(bus_a.match_count), 32'd0);

        // Over-long length clamps to MAX_LEN.
        do_cfg(8'b10110011, 4'd15, 1'b1);
        check("clamp_len", 32'(bus_a.cfg_len), 32'd8);
        send(32'b10110011, 8);
        check("clamp_count", 32'(bus_a.match_count), 32'd1);

        // Randomized configurations and streams.
        for (int r = 0; r < 24; r++) begin
            logic [3:0] len;
            len = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
            do_cfg(8'($urandom), len, 1'($urandom));
            for (int c = 0; c < 70; c++) begin
                int sel;
                sel = $urandom_range(0, 99);
                if (sel == 0) begin
                    cycle(1'b1, 1'b0, 1'b1, 1'($urandom));
                    do_cfg(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom));
                end else if (sel == 1) begin
                    cfg_pat = 8'($urandom); cfg_plen = 4'($urandom_range(1, 3));
                    cfg_ovl = 1'($urandom);
                    cycle(1'b0, 1'b1, 1'($urandom), 1'($urandom));
                end else begin
                    cycle(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
